register_file_scoreboard: RTL

Parametrised multi-port register file with per-register pending-write scoreboard, asynchronous clear and optional write-to-read bypass. Generalises the 2-read/1-write 32x32 register file to N read ports and M write ports, and adds reservation tracking so the pipeline's issue stage can stall on pending producers. Sits between decode/issue (reads, reservations) and writeback (writes).

---
 rtl/register_file_pkg.sv | 13 +
 rtl/register_file_scoreboard_if.sv | 33 +++
 rtl/register_read_port.sv | 42 ++++
 rtl/register_file_scoreboard.sv | 66 ++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared constants and port-slice helpers for the scoreboarded register file.
package register_file_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 32;
  localparam int DEFAULT_ADDRESS_WIDTH = 5;
  localparam int ZERO_REGISTER         = 0;

  // Base bit offset of port `port` inside a packed bus of `width`-bit lanes.
  function automatic int slice_base(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/register_file_scoreboard_if.sv
// Bus between issue/writeback (master) and the scoreboarded register file (slave).
interface register_file_scoreboard_if
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int READ_PORTS    = 2,
  parameter int WRITE_PORTS   = 1
) ();

  logic [READ_PORTS*ADDRESS_WIDTH-1:0]  read_address;
  logic [READ_PORTS*DATA_WIDTH-1:0]     read_data;
  logic [READ_PORTS-1:0]                read_ready;
  logic                                 reserve_enabled;
  logic [ADDRESS_WIDTH-1:0]             reserve_address;
  logic [WRITE_PORTS-1:0]               write_enabled;
  logic [WRITE_PORTS*ADDRESS_WIDTH-1:0] write_address;
  logic [WRITE_PORTS*DATA_WIDTH-1:0]    write_data;
  logic [(2**ADDRESS_WIDTH)-1:0]        busy_vector;

  modport master (
    output read_address, reserve_enabled, reserve_address,
           write_enabled, write_address, write_data,
    input  read_data, read_ready, busy_vector
  );

  modport slave (
    input  read_address, reserve_enabled, reserve_address,
           write_enabled, write_address, write_data,
    output read_data, read_ready, busy_vector
  );

endinterface

// File: rtl/register_read_port.sv
// One read port: zero-register override, optional write forwarding, ready derivation.
// Forwarding is compiled in when REGISTER_FILE_BYPASS_EN is defined.
module register_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int WRITE_PORTS   = 1
) (
  input  logic [ADDRESS_WIDTH-1:0]             address,
  input  logic [DATA_WIDTH-1:0]                stored_data,
  input  logic                                 stored_busy,
`ifdef REGISTER_FILE_BYPASS_EN
  input  logic [WRITE_PORTS-1:0]               write_enabled,
  input  logic [WRITE_PORTS*ADDRESS_WIDTH-1:0] write_address,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0]    write_data,
`endif
  output logic [DATA_WIDTH-1:0]                data,
  output logic                                 ready
);

  // Later (higher-index) writers overwrite earlier ones, matching storage priority.
  // A same-cycle reservation only lands next cycle, so it never lowers ready here.
  always_comb begin
    data  = stored_data;
    ready = !stored_busy;
`ifdef REGISTER_FILE_BYPASS_EN
    for (int j = 0; j < WRITE_PORTS; j++) begin
      if (write_enabled[j] &&
          write_address[slice_base(j, ADDRESS_WIDTH) +: ADDRESS_WIDTH] == address) begin
        data  = write_data[slice_base(j, DATA_WIDTH) +: DATA_WIDTH];
        ready = 1'b1;
      end
    end
`endif
    if (address == ADDRESS_WIDTH'(ZERO_REGISTER)) begin
      data  = '0;
      ready = 1'b1;
    end
  end

endmodule

// File: rtl/register_file_scoreboard.sv
// Multi-port register file with per-register pending-write (busy) scoreboard.
// Optional write-to-read forwarding under REGISTER_FILE_BYPASS_EN.
module register_file_scoreboard
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int READ_PORTS    = 2,
  parameter int WRITE_PORTS   = 1
) (
  input logic                 clock,
  input logic                 reset_n,
  register_file_scoreboard_if.slave bus
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDRESS = ADDRESS_WIDTH'(ZERO_REGISTER);

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      busy_q;

  // Nonblocking order encodes priority: higher write port beats lower, and a
  // reservation beats a write's busy clear (the new producer supersedes).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      busy_q <= '0;
    end else begin
      for (int j = 0; j < WRITE_PORTS; j++) begin
        if (bus.write_enabled[j] &&
            bus.write_address[slice_base(j, ADDRESS_WIDTH) +: ADDRESS_WIDTH] != ZERO_ADDRESS) begin
          data_q[bus.write_address[slice_base(j, ADDRESS_WIDTH) +: ADDRESS_WIDTH]] <=
            bus.write_data[slice_base(j, DATA_WIDTH) +: DATA_WIDTH];
          busy_q[bus.write_address[slice_base(j, ADDRESS_WIDTH) +: ADDRESS_WIDTH]] <= 1'b0;
        end
      end
      if (bus.reserve_enabled && bus.reserve_address != ZERO_ADDRESS)
        busy_q[bus.reserve_address] <= 1'b1;
    end
  end

  assign bus.busy_vector = busy_q;

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_read
    logic [ADDRESS_WIDTH-1:0] port_address;
    assign port_address = bus.read_address[slice_base(k, ADDRESS_WIDTH) +: ADDRESS_WIDTH];

    register_read_port #(
      .DATA_WIDTH    (DATA_WIDTH),
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .WRITE_PORTS   (WRITE_PORTS)
    ) u_port (
      .address       (port_address),
      .stored_data   (data_q[port_address]),
      .stored_busy   (busy_q[port_address]),
`ifdef REGISTER_FILE_BYPASS_EN
      .write_enabled (bus.write_enabled),
      .write_address (bus.write_address),
      .write_data    (bus.write_data),
`endif
      .data          (bus.read_data[slice_base(k, DATA_WIDTH) +: DATA_WIDTH]),
      .ready         (bus.read_ready[k])
    );
  end

endmodule
